// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI read bridges (instruction side now,
// data side later).
package inst_sram_axi_bridge_pkg;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_AR   = 2'd1,
        BR_R    = 2'd2,
        BR_RESP = 2'd3
    } br_state_e;

    // AXI encodings used by the bridges.
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [2:0] AXI_SIZE_WORD     = 3'b010;

    // Default ARID for instruction fetches.
    localparam logic [3:0] INST_ARID_DEFAULT = 4'd0;

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// inst_sram_axi_bridge: turns one IF-stage SRAM-like fetch into one single-beat
// AXI4 read and returns the word as a one-cycle data_ok pulse. One fetch is in
// flight at a time; a new request may be accepted in the response cycle.
module inst_sram_axi_bridge
    import inst_sram_axi_bridge_pkg::*;
#(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] INST_ARID = ID_W'(INST_ARID_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            inst_sram_req,
    input  logic            inst_sram_wr,
    input  logic [1:0]      inst_sram_size,
    input  logic [3:0]      inst_sram_wstrb,
    input  logic [31:0]     inst_sram_addr,
    input  logic [31:0]     inst_sram_wdata,
    output logic            inst_sram_addr_ok,
    output logic            inst_sram_data_ok,
    output logic [31:0]     inst_sram_rdata,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic            inst_axi_err
);

    br_state_e   state_q,  state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        axi_err_q, axi_err_d;
    logic        accept;

    // Write-side fields, the read ID and rlast carry no information for a
    // single-beat read with one fixed ID.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    // A request can be taken whenever no AR/R phase is in progress.
    assign inst_sram_addr_ok = (state_q == BR_IDLE) || (state_q == BR_RESP);
    assign accept            = inst_sram_addr_ok && inst_sram_req;

    // Next-state and register updates for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        rdata_d   = rdata_q;
        axi_err_d = axi_err_q;
        case (state_q)
            BR_IDLE: begin
                if (accept) begin
                    araddr_d = inst_sram_addr;
                    arsize_d = {1'b0, inst_sram_size};
                    state_d  = BR_AR;
                end
            end
            BR_AR: begin
                if (arready) begin
                    state_d = BR_R;
                end
            end
            BR_R: begin
                // arlen is 0, so the first beat is also the last one.
                if (rvalid) begin
                    rdata_d   = rdata;
                    axi_err_d = axi_err_q | (rresp != AXI_RESP_OKAY);
                    state_d   = BR_RESP;
                end
            end
            BR_RESP: begin
                // data_ok goes out for the old fetch while the new one is latched.
                if (accept) begin
                    araddr_d = inst_sram_addr;
                    arsize_d = {1'b0, inst_sram_size};
                    state_d  = BR_AR;
                end else begin
                    state_d  = BR_IDLE;
                end
            end
            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BR_IDLE;
            araddr_q  <= 32'd0;
            arsize_q  <= AXI_SIZE_WORD;
            rdata_q   <= 32'd0;
            axi_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            rdata_q   <= rdata_d;
            axi_err_q <= axi_err_d;
        end
    end

    // All handshake outputs decode the state register only, so no AXI input
    // reaches an SRAM-side output combinationally.
    assign arvalid           = (state_q == BR_AR);
    assign rready            = (state_q == BR_R);
    assign inst_sram_data_ok = (state_q == BR_RESP);
    assign inst_sram_rdata   = rdata_q;
    assign inst_axi_err      = axi_err_q;

    assign arid    = INST_ARID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = arsize_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Self-checking bench for inst_sram_axi_bridge: IF-side driver pushes expected
// words into a scoreboard, an AXI slave model answers with configurable delays,
// and a monitor pops/compares on every data_ok.
module tb_inst_sram_axi_bridge;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        inst_axi_err;

    inst_sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .inst_axi_err(inst_axi_err)
    );

    int          n_compared  = 0;
    int          n_mismatched = 0;
    int          n_accepted  = 0;
    int          dok_count   = 0;
    int          cyc         = 0;
    int          last_dok_cyc = 0;
    int          prev_dok_cyc = 0;
    logic [31:0] exp_q[$];

    // slave configuration
    bit          slave_en     = 1;
    bit          rand_mode    = 0;
    bit          err_mode     = 0;
    bit          override_en  = 0;
    logic [31:0] override_val = 32'd0;
    bit          stray_rvalid = 0;
    int          ar_delay     = 0;
    int          r_delay      = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h3C3CA5A5;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // AXI slave model: decides inputs at the falling edge from stable DUT outputs.
    initial begin
        int          s_phase;
        int          s_cnt;
        logic [31:0] s_addr;
        bit          rst_seen;
        s_phase = 0; s_cnt = 0; s_addr = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rid = 4'd0; rlast = 1'b0;
        forever begin
            @(posedge clk);
            rst_seen = reset;
            @(negedge clk);
            if (rst_seen) s_phase = 0;
            if (!slave_en) begin
                arready = 1'b0;
                rvalid  = stray_rvalid;
                rlast   = stray_rvalid;
                rdata   = 32'h12345678;
                rresp   = 2'b10;
            end else begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                if (s_phase == 0 && arvalid === 1'b1) begin
                    s_cnt   = rand_mode ? int'($urandom_range(0, 7)) : ar_delay;
                    s_phase = 1;
                end
                if (s_phase == 1) begin
                    if (s_cnt == 0) begin
                        arready = 1'b1;
                        s_addr  = araddr;
                        s_phase = 2;
                        s_cnt   = rand_mode ? int'($urandom_range(0, 7)) : r_delay;
                    end else begin
                        s_cnt--;
                    end
                end else if (s_phase == 2 && rready === 1'b1) begin
                    if (s_cnt == 0) begin
                        rvalid  = 1'b1;
                        rlast   = 1'b1;
                        rid     = 4'd0;
                        rdata   = override_en ? override_val : mem_word(s_addr);
                        rresp   = err_mode ? 2'b10 : 2'b00;
                        s_phase = 0;
                    end else begin
                        s_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: scoreboard pop on data_ok and AR-channel stability while stalled.
    initial begin
        bit          mon_rst;
        bit          prev_wait;
        logic [31:0] prev_addr;
        logic [31:0] exp;
        prev_wait = 0; prev_addr = 32'd0;
        forever begin
            @(posedge clk);
            mon_rst = reset;
            @(negedge clk);
            #1;
            if (!mon_rst && prev_wait) begin
                n_compared++;
                if (arvalid !== 1'b1) begin
                    n_mismatched++;
                    $display("FAIL arvalid_held: arvalid=%b, required 1 until arready", arvalid);
                end
                n_compared++;
                if (araddr !== prev_addr) begin
                    n_mismatched++;
                    $display("FAIL araddr_held: araddr=%h, required %h", araddr, prev_addr);
                end
            end
            prev_wait = (arvalid === 1'b1) && (arready !== 1'b1);
            prev_addr = araddr;
            if (inst_sram_data_ok === 1'b1) begin
                dok_count++;
                prev_dok_cyc = last_dok_cyc;
                last_dok_cyc = cyc;
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL unexpected_data_ok: rdata=%h, required no pulse", inst_sram_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    $display("fetch %0d: rdata=%h expected=%h", dok_count, inst_sram_rdata, exp);
                    if (inst_sram_rdata !== exp) begin
                        n_mismatched++;
                        $display("FAIL fetch_data: rdata=%h, required %h", inst_sram_rdata, exp);
                    end
                end
            end
        end
    end

    // Present a request (entered at a falling edge); returns at the falling edge
    // after the accepting rising edge with req still asserted.
    task automatic issue(input logic [31:0] a);
        bit ok;
        ok = 0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = a;
        inst_sram_size = 2'b10;
        for (int i = 0; i < 60; i++) begin
            if (inst_sram_addr_ok === 1'b1) begin
                exp_q.push_back(override_en ? override_val : mem_word(a));
                n_accepted++;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        n_compared++;
        if (!ok) begin
            n_mismatched++;
            $display("FAIL accept_timeout: addr_ok never seen for %h, required acceptance", a);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        n_compared++;
        if (!done) begin
            n_mismatched++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("FAIL rst_addr_ok: %b, required 1", inst_sram_addr_ok); end
        n_compared++; if (inst_sram_data_ok !== 1'b0) begin n_mismatched++; $display("FAIL rst_data_ok: %b, required 0", inst_sram_data_ok); end
        n_compared++; if (inst_sram_rdata !== 32'd0) begin n_mismatched++; $display("FAIL rst_rdata: %h, required 0", inst_sram_rdata); end
        n_compared++; if (arvalid !== 1'b0) begin n_mismatched++; $display("FAIL rst_arvalid: %b, required 0", arvalid); end
        n_compared++; if (araddr !== 32'd0) begin n_mismatched++; $display("FAIL rst_araddr: %h, required 0", araddr); end
        n_compared++; if (arsize !== 3'b010) begin n_mismatched++; $display("FAIL rst_arsize: %b, required 010", arsize); end
        n_compared++; if (rready !== 1'b0) begin n_mismatched++; $display("FAIL rst_rready: %b, required 0", rready); end
        n_compared++; if (inst_axi_err !== 1'b0) begin n_mismatched++; $display("FAIL rst_err: %b, required 0", inst_axi_err); end
        n_compared++; if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0}) begin
            n_mismatched++;
            $display("FAIL const_ar_fields: arid=%h arlen=%h arburst=%b arlock=%b arcache=%h arprot=%h, required 0/0/01/0/0/0",
                     arid, arlen, arburst, arlock, arcache, arprot);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        int d0;
        ar_delay = 0; r_delay = 0;
        override_en = 1; override_val = 32'h02800C0C;
        d0 = dok_count;
        issue(32'h1C000000);
        inst_sram_req = 1'b0;
        n_compared++; if (arvalid !== 1'b1) begin n_mismatched++; $display("FAIL single_arvalid: %b, required 1", arvalid); end
        n_compared++; if (araddr !== 32'h1C000000) begin n_mismatched++; $display("FAIL single_araddr: %h, required 1c000000", araddr); end
        n_compared++; if (arsize !== 3'b010) begin n_mismatched++; $display("FAIL single_arsize: %b, required 010", arsize); end
        n_compared++; if (arlen !== 8'd0) begin n_mismatched++; $display("FAIL single_arlen: %h, required 0", arlen); end
        repeat (2) @(negedge clk);
        n_compared++; if (inst_sram_data_ok !== 1'b1) begin n_mismatched++; $display("FAIL single_latency: data_ok=%b three cycles after accept, required 1", inst_sram_data_ok); end
        repeat (5) @(negedge clk);
        n_compared++; if (dok_count - d0 !== 1) begin n_mismatched++; $display("FAIL single_pulse_count: %0d, required 1", dok_count - d0); end
        n_compared++; if (inst_axi_err !== 1'b0) begin n_mismatched++; $display("FAIL single_err: %b, required 0", inst_axi_err); end
        override_en = 0;
    endtask

    task automatic test_arready_stall();
        ar_delay = 5;
        issue(32'h1C000000);
        inst_sram_addr = 32'h1C000004;
        for (int i = 0; i < 5; i++) begin
            n_compared++; if (araddr !== 32'h1C000000) begin n_mismatched++; $display("FAIL stall_araddr[%0d]: %h, required 1c000000", i, araddr); end
            n_compared++; if (inst_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("FAIL stall_addr_ok[%0d]: %b, required 0", i, inst_sram_addr_ok); end
            n_compared++; if (arvalid !== 1'b1) begin n_mismatched++; $display("FAIL stall_arvalid[%0d]: %b, required 1", i, arvalid); end
            @(negedge clk);
        end
        inst_sram_req = 1'b0;
        ar_delay = 0;
        drain();
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = dok_count;
        issue(32'h1C000000);
        issue(32'h1C000004);
        n_compared++; if (arvalid !== 1'b1 || araddr !== 32'h1C000004) begin n_mismatched++; $display("FAIL b2b_second_ar: arvalid=%b araddr=%h, required 1/1c000004", arvalid, araddr); end
        n_compared++; if (cyc - last_dok_cyc !== 1) begin n_mismatched++; $display("FAIL b2b_ar_timing: second AR %0d cycles after data_ok, required 1", cyc - last_dok_cyc); end
        inst_sram_req = 1'b0;
        drain();
        n_compared++; if (dok_count - d0 !== 2) begin n_mismatched++; $display("FAIL b2b_pulses: %0d, required 2", dok_count - d0); end
        n_compared++; if (last_dok_cyc - prev_dok_cyc !== 3) begin n_mismatched++; $display("FAIL b2b_spacing: %0d cycles, required 3", last_dok_cyc - prev_dok_cyc); end
    endtask

    task automatic test_error_response();
        err_mode = 1; override_en = 1; override_val = 32'hDEADBEEF;
        issue(32'h1C000008);
        inst_sram_req = 1'b0;
        drain();
        n_compared++; if (inst_axi_err !== 1'b1) begin n_mismatched++; $display("FAIL err_set: %b, required 1", inst_axi_err); end
        err_mode = 0; override_en = 0;
        issue(32'h1C00000C);
        inst_sram_req = 1'b0;
        drain();
        n_compared++; if (inst_axi_err !== 1'b1) begin n_mismatched++; $display("FAIL err_sticky: %b, required 1", inst_axi_err); end
    endtask

    task automatic test_reset_mid_r();
        int d0;
        r_delay = 3;
        issue(32'h1C000010);
        inst_sram_req = 1'b0;
        @(negedge clk);
        n_compared++; if (rready !== 1'b1) begin n_mismatched++; $display("FAIL midr_in_r: rready=%b, required 1", rready); end
        d0 = dok_count;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_compared++; if (rready !== 1'b0) begin n_mismatched++; $display("FAIL midr_rready: %b, required 0", rready); end
        n_compared++; if (arvalid !== 1'b0) begin n_mismatched++; $display("FAIL midr_arvalid: %b, required 0", arvalid); end
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("FAIL midr_addr_ok: %b, required 1", inst_sram_addr_ok); end
        n_compared++; if (inst_axi_err !== 1'b0) begin n_mismatched++; $display("FAIL midr_err_cleared: %b, required 0", inst_axi_err); end
        reset = 1'b0;
        r_delay = 0;
        repeat (8) @(negedge clk);
        n_compared++; if (dok_count !== d0) begin n_mismatched++; $display("FAIL midr_no_pulse: %0d pulses, required 0", dok_count - d0); end
    endtask

    task automatic test_stray_rvalid();
        slave_en = 0;
        stray_rvalid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_compared++; if (inst_sram_data_ok !== 1'b0) begin n_mismatched++; $display("FAIL stray_data_ok[%0d]: %b, required 0", i, inst_sram_data_ok); end
        end
        @(negedge clk);
        n_compared++; if (inst_sram_rdata !== 32'd0) begin n_mismatched++; $display("FAIL stray_rdata: %h, required 0", inst_sram_rdata); end
        n_compared++; if (inst_axi_err !== 1'b0) begin n_mismatched++; $display("FAIL stray_err: %b, required 0", inst_axi_err); end
        stray_rvalid = 0;
        slave_en = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_protocol();
        int a0, d0;
        logic [31:0] a;
        rand_mode = 1;
        a0 = n_accepted;
        d0 = dok_count;
        for (int i = 0; i < 1000; i++) begin
            a = 32'h1C000000 | ($urandom_range(0, 16383) << 2);
            issue(a);
            if ($urandom_range(0, 1) == 1) begin
                inst_sram_req = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        inst_sram_req = 1'b0;
        drain();
        rand_mode = 0;
        n_compared++; if (dok_count - d0 !== n_accepted - a0) begin n_mismatched++; $display("FAIL rand_counts: data_ok=%0d, required %0d", dok_count - d0, n_accepted - a0); end
        n_compared++; if (n_accepted - a0 !== 1000) begin n_mismatched++; $display("FAIL rand_accepted: %0d, required 1000", n_accepted - a0); end
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'b10;
        inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_arready_stall();
        test_back_to_back();
        test_error_response();
        test_reset_mid_r();
        test_stray_rvalid();
        test_random_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/inst_sram_axi_bridge.md
# inst_sram_axi_bridge

Converts the instruction-side SRAM-like request/response protocol driven by the IF stage into a single-beat AXI4 read transaction and returns the fetched word as a one-cycle `data_ok` pulse. It sits between the IF stage's `inst_sram_*` port and the CPU top-level AXI read arbiter. It tracks exactly one outstanding fetch and accepts a new request in the same cycle the previous response is returned. IF's cancel logic relies on one guarantee: every accepted request produces exactly one `data_ok`.

## Interface
Parameters:
- `ID_W`, default 4: AXI ID width.
- `INST_ARID`, default 4'd0: fixed ARID for instruction fetches.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_sram_req` in 1: request valid.
- `inst_sram_wr` in 1: write flag. Must be 0; ignored, every request is treated as a read.
- `inst_sram_size` in 2: log2 bytes; 2'b10 for fetch.
- `inst_sram_wstrb` in 4: ignored.
- `inst_sram_addr` in 32: byte address, sampled only at the handshake.
- `inst_sram_wdata` in 32: ignored.
- `inst_sram_addr_ok` out 1: request accepted this cycle when `req` is also 1.
- `inst_sram_data_ok` out 1: one-cycle pulse, `rdata` valid.
- `inst_sram_rdata` out 32: returned word.
- `arid` out ID_W, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3, `arvalid` out 1: AXI read address channel outputs.
- `arready` in 1: AXI read address channel ready.
- `rid` in ID_W, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1: AXI read data channel inputs.
- `rready` out 1: AXI read data channel ready.
- `inst_axi_err` out 1: sticky flag, set when any beat returns `rresp != 2'b00`.

## Operation
- The FSM has four states: IDLE, AR, R, RESP.
- `addr_ok = (state==IDLE) || (state==RESP)`, combinational from state only; it does not depend on `req`.
- **IDLE**: on `req && addr_ok`, latch `addr` into `araddr_q` and `{1'b0,size}` into `arsize_q`, then go to AR.
- **AR**: `arvalid=1` with `araddr=araddr_q` and `arsize=arsize_q`; these are held stable until `arready`. On `arvalid && arready`, go to R.
- **R**: `rready=1`. On `rvalid` (with `rlast=1`, since arlen=0), latch `rdata` into `rdata_q` and OR `(rresp!=0)` into `inst_axi_err`, then go to RESP.
- **RESP**: `data_ok=1` and `inst_sram_rdata=rdata_q`.
  - If `req` is 1 this cycle, latch the new addr/size and go to AR.
  - Otherwise go to IDLE.
- Constant AXI fields: `arid=INST_ARID`, `arlen=0`, `arburst=2'b01` (INCR), `arlock=0`, `arcache=0`, `arprot=0`.
- The `rid` value is not checked. An error response still returns data and still pulses `data_ok`.
- `inst_sram_rdata` holds `rdata_q` between pulses; it is not cleared.

## Timing
- Reset values (state IDLE):
  - `addr_ok=1`
  - `data_ok=0`
  - `rdata=0`
  - `arvalid=0`, `araddr=0`
  - `arsize=3'b010`
  - `rready=0`
  - `inst_axi_err=0`
- Latency with an accepted request in cycle T, `arready` first high in cycle A, `rvalid` first high in cycle D:
  - AR state is entered at T+1.
  - R state is entered at A+1.
  - `data_ok` is high in D+1.
  - Minimum request-to-`data_ok` is 3 cycles, when `arready` is high at T+1 and `rvalid` is high at T+2.
- Back-to-back requests: with a `req` in the RESP cycle, the next AR starts the following cycle. Sustained throughput with zero-wait AXI is one fetch per 3 cycles.
- Simultaneous `data_ok` and acceptance in RESP: the returned data belongs to the old request, and the latched address belongs to the new one.
- `rvalid` arriving in any state other than R: it is not consumed because `rready=0`, and it has no effect.
- Reset mid-transaction: at the next edge the bridge is in IDLE and `arvalid`/`rready` drop. The AXI slave is reset by the same `reset`, so no transaction is left dangling.
- There are no combinational paths from AXI inputs to sram-side outputs. `addr_ok` depends on state only.

## Structure
- Shared header:
  - State encodings (`BR_IDLE=2'd0`, `BR_AR=2'd1`, `BR_R=2'd2`, `BR_RESP=2'd3`).
  - `AXI_BURST_INCR=2'b01`.
  - Default `INST_ARID`.
  - The OKAY encoding `2'b00`.
  The data-side bridge will reuse these.
- Single flat module; no sub-module. The FSM and the address/size/data registers are small enough to sit inline.

## Test plan
- **Single fetch**: reset, `req=1` with addr 0x1C000000, `arready` high immediately, `rvalid` 2 cycles later with data 0x02800C0C.
  - AR carries araddr 0x1C000000, arsize 3'b010, arlen 0.
  - `data_ok` pulses exactly once with 0x02800C0C.
  - `inst_axi_err` stays 0.
- **arready stall**: hold `arready=0` for 5 cycles while IF changes `inst_sram_addr` to 0x1C000004.
  - `araddr` stays 0x1C000000 throughout the stall.
  - `addr_ok` stays 0 throughout the stall.
- **Back-to-back**: keep `req=1` with addr 0x1C000000 then 0x1C000004, zero-wait slave.
  - The second AR issues the cycle after the first `data_ok`.
  - Two `data_ok` pulses arrive 3 cycles apart, with matching data order.
- **Error response**: return `rresp=2'b10` with data 0xDEADBEEF.
  - `data_ok` pulses with 0xDEADBEEF.
  - `inst_axi_err` becomes 1 and holds until reset.
- **Reset mid-R**: assert `reset` one cycle while in R.
  - Next cycle: state IDLE, `rready=0`, `arvalid=0`, `addr_ok=1`.
  - No `data_ok` pulse for the aborted request.
- **Protocol check (random slave delays 0–7 cycles, 1000 fetches)**:
  - The `data_ok` count equals the accepted-request count.
  - `arvalid` never drops before `arready`.
